xbar_rr_slave_ctrl: RTL and testbench

Per-slave transaction controller for the crossbar. It shares one slave port among NUM_MASTERS masters using round-robin arbitration. A grant is held for the whole transaction, until the slave acks, the master withdraws, or a watchdog timeout fires. It drives the slave request, routes ack back to the owning master, and flags timeouts per master.

---
 rtl/xbar_rr_slave_ctrl.sv | 121 ++++++++++++
 tb/tb_xbar_rr_slave_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/xbar_rr_slave_ctrl.sv
// Per-slave transaction controller for the crossbar.
// Shares one slave port among NUM_MASTERS masters using round-robin arbitration.
// A grant is held until the slave acks, the owner withdraws, or the watchdog fires.
module xbar_rr_slave_ctrl #(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned IDW         = 2,
   parameter int unsigned TIMEOUT     = 16,
   parameter int unsigned TW          = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] req,
   input  logic                   ack,
   output logic [NUM_MASTERS-1:0] grant,
   output logic [IDW-1:0]         grant_id,
   output logic                   slave_req,
   output logic [NUM_MASTERS-1:0] ack_out,
   output logic [NUM_MASTERS-1:0] err,
   output logic                   busy
);

   localparam logic StIdle = 1'b0;
   localparam logic StBusy = 1'b1;

   // Guarded so TIMEOUT == 0 does not underflow; the compare is disabled in that case anyway.
   localparam int unsigned TimeoutM1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [TW-1:0] TimerLast = TW'(TimeoutM1);
   localparam logic [IDW-1:0] LastId = IDW'(NUM_MASTERS - 1);

   logic                   state_q, state_d;
   logic [IDW-1:0]         ptr_q, ptr_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDW-1:0]         grant_id_q, grant_id_d;

   logic           owner_req;
   logic           timeout_hit;
   logic           found;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] ptr_adv;

   assign owner_req   = req[grant_id_q];
   assign timeout_hit = (TIMEOUT != 0) && (timer_q == TimerLast);
   assign ptr_adv     = (grant_id_q == LastId) ? '0 : grant_id_q + IDW'(1);

   // Round-robin search: first requester at or after ptr, wrapping modulo NUM_MASTERS.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         int unsigned cand;
         cand = int'(ptr_q) + i;
         if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = IDW'(cand);
         end
      end
   end

   // Next-state: IDLE grants the winner; BUSY exits on ack, withdrawal, then timeout.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      timer_d    = timer_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      if (state_q == StIdle) begin
         if (found) begin
            state_d         = StBusy;
            grant_d         = '0;
            grant_d[winner] = 1'b1;
            grant_id_d      = winner;
            timer_d         = '0;
         end
      end else begin
         if ((ack && owner_req) || !owner_req || timeout_hit) begin
            state_d    = StIdle;
            ptr_d      = ptr_adv;
            grant_d    = '0;
            grant_id_d = '0;
         end else begin
            // With the watchdog disabled this simply wraps and is never looked at.
            timer_d = timer_q + TW'(1);
         end
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         timer_q    <= '0;
         grant_q    <= '0;
         grant_id_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         timer_q    <= timer_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
      end
   end

   // Combinational slave request, ack routing and timeout pulse for the current owner.
   always_comb begin
      ack_out = '0;
      err     = '0;
      if (busy && owner_req) begin
         if (ack) ack_out[grant_id_q] = 1'b1;
         else if (timeout_hit) err[grant_id_q] = 1'b1;
      end
   end

   assign busy      = (state_q == StBusy);
   assign slave_req = busy & owner_req;
   assign grant     = grant_q;
   assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_xbar_rr_slave_ctrl.sv
// Directed bench for xbar_rr_slave_ctrl; expected grant owners are queued as stimulus is driven.
module tb_xbar_rr_slave_ctrl;

   localparam int unsigned N   = 4;
   localparam int unsigned IDW = 2;
   localparam int unsigned TO  = 4;
   localparam int unsigned TW  = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic           ack;
   logic [N-1:0]   grant;
   logic [IDW-1:0] grant_id;
   logic           slave_req;
   logic [N-1:0]   ack_out;
   logic [N-1:0]   err;
   logic           busy;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned exp_q[$];
   int unsigned g;

   xbar_rr_slave_ctrl #(
      .NUM_MASTERS(N),
      .IDW        (IDW),
      .TIMEOUT    (TO),
      .TW         (TW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .ack      (ack),
      .grant    (grant),
      .grant_id (grant_id),
      .slave_req(slave_req),
      .ack_out  (ack_out),
      .err      (err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
   task automatic cyc(input logic [N-1:0] r, input logic a);
      @(negedge clk);
      req = r;
      ack = a;
      #1;
   endtask

   // Pop the next expected owner and compare against the registered grant outputs.
   task automatic chk_grant(input string tag, output int unsigned e);
      e = 0;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: observed grant_id %0d expected none queued", tag, grant_id);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_id"}, 32'(grant_id), e);
         chk({tag, "_oh"}, 32'(grant), 32'(1) << e);
         chk({tag, "_busy"}, 32'(busy), 1);
      end
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      ack   = 1'b0;
      #3;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_id", 32'(grant_id), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sreq", 32'(slave_req), 0);
      chk("rst_ackout", 32'(ack_out), 0);
      chk("rst_err", 32'(err), 0);
      @(negedge clk);
      reset = 1'b0;

      // Single master 0, ack on third busy cycle.
      cyc(4'b0001, 1'b0);
      chk("t1_idle_grant", 32'(grant), 0);
      exp_q.push_back(0);
      cyc(4'b0001, 1'b0);
      chk_grant("t1_grant", g);
      chk("t1_sreq", 32'(slave_req), 1);
      cyc(4'b0001, 1'b0);
      chk("t1_hold", 32'(grant), 32'b0001);
      cyc(4'b0001, 1'b1);
      chk("t1_ackout", 32'(ack_out), 32'b0001);
      chk("t1_err", 32'(err), 0);

      // All requesting: rotation starts at 1 since ptr advanced past master 0.
      exp_q.push_back(1);
      exp_q.push_back(2);
      exp_q.push_back(3);
      exp_q.push_back(0);
      exp_q.push_back(1);
      for (int i = 0; i < 5; i++) begin
         cyc(4'b1111, 1'b0);
         chk("t2_gap_busy", 32'(busy), 0);
         chk("t2_gap_grant", 32'(grant), 0);
         cyc(4'b1111, 1'b0);
         chk_grant("t2_grant", g);
         cyc(4'b1111, 1'b0);
         cyc(4'b1111, 1'b1);
         chk("t2_ackout", 32'(ack_out), 32'(1) << g);
      end

      // Owner 2 withdraws with a stray ack; next grant goes to 3.
      cyc(4'b1111, 1'b0);
      chk("t3_gap_busy", 32'(busy), 0);
      exp_q.push_back(2);
      cyc(4'b1111, 1'b0);
      chk_grant("t3_grant2", g);
      cyc(4'b1011, 1'b1);
      chk("t3_sreq", 32'(slave_req), 0);
      chk("t3_ackout", 32'(ack_out), 0);
      chk("t3_err", 32'(err), 0);
      cyc(4'b1011, 1'b0);
      chk("t3_idle_busy", 32'(busy), 0);
      exp_q.push_back(3);
      cyc(4'b1011, 1'b0);
      chk_grant("t3_grant3", g);
      cyc(4'b1011, 1'b1);
      chk("t3_ack3", 32'(ack_out), 32'b1000);

      // Owner 1 times out on its fourth busy cycle.
      cyc(4'b0010, 1'b0);
      chk("t4_idle_busy", 32'(busy), 0);
      exp_q.push_back(1);
      cyc(4'b0010, 1'b0);
      chk_grant("t4_grant1", g);
      chk("t4_err_b1", 32'(err), 0);
      cyc(4'b0010, 1'b0);
      chk("t4_err_b2", 32'(err), 0);
      cyc(4'b0010, 1'b0);
      chk("t4_err_b3", 32'(err), 0);
      cyc(4'b0110, 1'b0);
      chk("t4_err_b4", 32'(err), 32'b0010);
      chk("t4_ackout", 32'(ack_out), 0);

      // Ack while idle is ignored.
      cyc(4'b0110, 1'b1);
      chk("t5_idle_busy", 32'(busy), 0);
      chk("t5_idle_ackout", 32'(ack_out), 0);
      chk("t5_idle_err", 32'(err), 0);
      exp_q.push_back(2);
      cyc(4'b0110, 1'b0);
      chk_grant("t5_grant2", g);
      cyc(4'b0110, 1'b0);
      cyc(4'b0110, 1'b0);
      // Ack coincides with the timeout threshold: success wins.
      cyc(4'b0110, 1'b1);
      chk("t5_thr_ackout", 32'(ack_out), 32'b0100);
      chk("t5_thr_err", 32'(err), 0);

      // Asynchronous reset mid-transaction.
      cyc(4'b1111, 1'b0);
      chk("t6_idle_busy", 32'(busy), 0);
      exp_q.push_back(3);
      cyc(4'b1111, 1'b0);
      chk_grant("t6_grant3", g);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_grant", 32'(grant), 0);
      chk("t6_rst_id", 32'(grant_id), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_sreq", 32'(slave_req), 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t6_post_busy", 32'(busy), 0);
      exp_q.push_back(0);
      cyc(4'b1111, 1'b0);
      chk_grant("t6_grant0", g);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
